// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin sequencer in front of a single-port
// data memory (async read, write on posedge). One access in flight at a time.
// Each access takes one IDLE arbitration cycle plus one ACCESS cycle. The ack
// and the registered read data appear in the cycle after ACCESS.
// Optional build macro DMEM_ARB_RANGE_CHK_EN adds the mN_err ports. It also
// adds an alignment/depth check that blocks illegal writes and zeroes read data.
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
`ifdef DMEM_ARB_RANGE_CHK_EN
    output logic              m0_err,
`endif
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_RANGE_CHK_EN
    output logic              m1_err,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]        state;
    logic              prio;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wd;

    logic              eff0, eff1, winner;
    logic              legal;
    logic [DATA_W-1:0] rd_val;

    // A master whose ack is high this cycle is finishing; it cannot re-win yet,
    // which lets the other master take the slot in the ack cycle.
    assign eff0 = m0_req & ~m0_ack;
    assign eff1 = m1_req & ~m1_ack;

    // Pick the sole requester, or the favoured master when both are asking.
    always_comb begin
        winner = 1'b0;
        if (eff0 && eff1) winner = prio;
        else if (eff1)    winner = 1'b1;
    end

`ifdef DMEM_ARB_RANGE_CHK_EN
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

    // The access must be word-aligned and must fall inside the memory.
    always_comb begin
        legal = (lat_addr[1:0] == 2'b00) &&
                ({2'b00, lat_addr[ADDR_W-1:2]} < DEPTH_LIM);
    end
`else
    assign legal = 1'b1;
`endif

    assign rd_val   = legal ? mem_rd : '0;
    assign busy     = (state == S_ACCESS);
    assign mem_addr = lat_addr;
    assign mem_wd   = lat_wd;
    // Reset in the ACCESS cycle must not let a half-finished write land.
    assign mem_we   = busy & lat_we & legal & ~rst;

    // Arbitration FSM, payload latch, and registered acknowledge/read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            prio     <= 1'b0;
            lat_id   <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
`ifdef DMEM_ARB_RANGE_CHK_EN
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHK_EN
            m0_err <= 1'b0;
            m1_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (eff0 || eff1) begin
                        lat_id   <= winner;
                        lat_we   <= winner ? m1_we   : m0_we;
                        lat_addr <= winner ? m1_addr : m0_addr;
                        lat_wd   <= winner ? m1_wd   : m0_wd;
                        prio     <= ~winner;
                        state    <= S_ACCESS;
                    end
                end
                default: begin
                    if (lat_id) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= rd_val;
`ifdef DMEM_ARB_RANGE_CHK_EN
                        m1_err   <= ~legal;
`endif
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= rd_val;
`ifdef DMEM_ARB_RANGE_CHK_EN
                        m0_err   <= ~legal;
`endif
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural memory.
// Expected read data is queued per master when a request is driven. A monitor
// pops the queue when the ack arrives. Cycle timing is checked inline.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wd = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wd = '0;
    logic        m0_ack, m1_ack, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_RANGE_CHK_EN
    logic        m0_err, m1_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    logic [31:0] tmem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
`ifdef DMEM_ARB_RANGE_CHK_EN
        .m0_err(m0_err),
`endif
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_RANGE_CHK_EN
        .m1_err(m1_err),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .busy(busy)
    );

    // Behavioural single-port memory: async read, write on posedge.
    assign mem_rd = tmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tmem[i] <= 32'hA000_0000 | i;
        end else if (mem_we) begin
            tmem[mem_addr[9:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic e);
        exp_t r;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    // Scoreboard monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && m0_ack) begin
            if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
            else begin
                mon_e = q0.pop_front();
                chk("m0_rdata", m0_rdata, mon_e.data);
`ifdef DMEM_ARB_RANGE_CHK_EN
                chk("m0_err", m0_err, mon_e.err);
`endif
            end
        end
        if (!rst && m1_ack) begin
            if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
            else begin
                mon_e = q1.pop_front();
                chk("m1_rdata", m1_rdata, mon_e.data);
`ifdef DMEM_ARB_RANGE_CHK_EN
                chk("m1_err", m1_err, mon_e.err);
`endif
            end
        end
    end

    initial begin
        // Reset and memory preload
        rst = 1'b1; mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        tick();

        // 1: m0 write 0x10
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'hDEAD_BEEF;
        q0.push_back(mk(32'hA000_0004, 1'b0));
        #1 chk("t1_we_idle", mem_we, 0);
        tick();
        chk("t1_we_access", mem_we, 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wd", mem_wd, 32'hDEAD_BEEF);
        chk("t1_busy", busy, 1);
        chk("t1_ack_early", m0_ack, 0);
        tick();
        chk("t1_ack", m0_ack, 1);
        chk("t1_we_after", mem_we, 0);
        m0_req = 0; m0_we = 0;
        tick();
        chk("t1_ack_pulse", m0_ack, 0);

        // 2: m1 read 0x10 returns written data
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        q1.push_back(mk(32'hDEAD_BEEF, 1'b0));
        tick();
        chk("t2_we", mem_we, 0);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_ack", m1_ack, 1);
        chk("t2_m0_ack", m0_ack, 0);
        chk("t2_m0_hold", m0_rdata, 32'hA000_0004);
        m1_req = 0;
        tick();

        // 3: simultaneous requests after reset, then with prio on m1
        rst = 1; tick(); rst = 0;
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
        q0.push_back(mk(32'hA000_0008, 1'b0));
        q1.push_back(mk(32'hA000_0009, 1'b0));
        tick();
        tick();
        chk("t3_m0_first", m0_ack, 1);
        chk("t3_m1_not_yet", m1_ack, 0);
        m0_req = 0;
        tick();
        chk("t3_busy_m1", busy, 1);
        tick();
        chk("t3_m1_ack", m1_ack, 1);
        chk("t3_m0_idle", m0_ack, 0);
        m1_req = 0;
        tick();
        m0_req = 1; m0_addr = 32'h28;
        q0.push_back(mk(32'hA000_000A, 1'b0));
        tick(); tick();
        chk("t3_solo_ack", m0_ack, 1);
        m0_req = 0;
        tick();
        m0_req = 1; m0_addr = 32'h2C; m1_req = 1; m1_addr = 32'h30;
        q1.push_back(mk(32'hA000_000C, 1'b0));
        q0.push_back(mk(32'hA000_000B, 1'b0));
        tick(); tick();
        chk("t3_m1_first", m1_ack, 1);
        chk("t3_m0_second", m0_ack, 0);
        m1_req = 0;
        tick(); tick();
        chk("t3_m0_ack", m0_ack, 1);
        m0_req = 0;
        tick();

        // 4: m0 holds request for four reads
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int k = 0; k < 4; k++) q0.push_back(mk(32'hDEAD_BEEF, 1'b0));
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk($sformatf("t4_ack_c%0d", c), m0_ack, (c >= 2 && (c - 2) % 3 == 0));
            chk($sformatf("t4_busy_c%0d", c), busy, (c % 3 == 1));
        end
        m0_req = 0;
        tick();
        chk("t4_done_busy", busy, 0);
        chk("t4_done_ack", m0_ack, 0);

        // 5: reset during write ACCESS
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wd = 32'h1234;
        tick();
        chk("t5_busy", busy, 1);
        rst = 1; m0_req = 0; m0_we = 0;
        #1 chk("t5_we_suppressed", mem_we, 0);
        tick();
        rst = 0;
        chk("t5_no_ack", m0_ack, 0);
        chk("t5_idle", busy, 0);
        tick();
        chk("t5_no_ack_late", m0_ack, 0);
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
        q0.push_back(mk(32'hA000_0008, 1'b0));
        q1.push_back(mk(32'hA000_0009, 1'b0));
        tick(); tick();
        chk("t5_prio_reset_m0", m0_ack, 1);
        m0_req = 0;
        tick(); tick();
        chk("t5_m1_ack", m1_ack, 1);
        m1_req = 0;
        tick();

        // 6: out-of-range and misaligned writes from m1
        m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wd = 32'h55;
`ifdef DMEM_ARB_RANGE_CHK_EN
        q1.push_back(mk(32'h0, 1'b1));
`else
        q1.push_back(mk(32'hA000_0040, 1'b0));
`endif
        tick();
`ifdef DMEM_ARB_RANGE_CHK_EN
        chk("t6_oor_we", mem_we, 0);
`else
        chk("t6_oor_we", mem_we, 1);
        chk("t6_oor_addr", mem_addr, 32'h100);
`endif
        tick();
        chk("t6_oor_ack", m1_ack, 1);
        m1_req = 0;
        tick();
        m1_req = 1; m1_addr = 32'h13; m1_wd = 32'h66;
`ifdef DMEM_ARB_RANGE_CHK_EN
        q1.push_back(mk(32'h0, 1'b1));
`else
        q1.push_back(mk(32'hDEAD_BEEF, 1'b0));
`endif
        tick();
`ifdef DMEM_ARB_RANGE_CHK_EN
        chk("t6_mis_we", mem_we, 0);
`else
        chk("t6_mis_we", mem_we, 1);
        chk("t6_mis_addr", mem_addr, 32'h13);
`endif
        tick();
        chk("t6_mis_ack", m1_ack, 1);
        m1_req = 0; m1_we = 0;
        tick();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
`ifdef DMEM_ARB_RANGE_CHK_EN
        q0.push_back(mk(32'hDEAD_BEEF, 1'b0));
`else
        q0.push_back(mk(32'h66, 1'b0));
`endif
        tick(); tick();
        chk("t6_readback_ack", m0_ack, 1);
        m0_req = 0;
        tick(); tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
